ic_assoc: RTL
=============

# ic_assoc

Parametrised set-associative instruction cache; successor to the direct-mapped single-way IC. It sits between the fetch stage and the instruction memory port. Hits return the fetch word combinationally in the lookup cycle. Misses stall fetch while a refill FSM brings in the line critical-word-first through a valid/ready request port. It adds configurable ways and line length, round-robin replacement, a whole-cache flush, and saturating hit/miss counters.

## Interface
- ADDR_W, 32, byte-address width
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16
- SETS, 1024, number of sets; power of two
- WAYS, 2, associativity; 1, 2 or 4
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; blocks new refill start and counter updates
- flush  in  1  single-cycle request to invalidate the whole cache
- data_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- data  out  32  fetch word; valid when stop=0
- stop  out  1  fetch must wait (miss, refill or flush in progress)
- mem_req_valid  out  1  refill beat request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word-aligned refill beat address
- mem_resp_valid  in  1  response word valid
- mem_resp_data  in  32  response word
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating refill counter

## Operation
- Address fields: OFST_W=clog2(LINE_WORDS) at [OFST_W+1:2]; IDX_W=clog2(SETS) above the offset; TAG_W=ADDR_W-IDX_W-OFST_W-2.
- Hit = any way in set idx with valid and matching tag. At most one way matches; data is that way's word at ofst.
- stop = 1 whenever state != IDLE, or state==IDLE and there is no hit.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT, FLUSH.
- IDLE, no hit, stall=0: latch tag, idx and ofst as start word. Select victim: lowest-index invalid way, else the set's round-robin pointer. Increment miss_count. Go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_req_addr={tag, idx, beat_ofst, 2'b00}. On mem_req_ready, go to REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid, write the word to victim way at beat_ofst. beat_ofst advances modulo LINE_WORDS, so the order is ofst, ofst+1, …, wrapping. After LINE_WORDS beats: write tag, set valid, advance the set's round-robin pointer modulo WAYS, go to IDLE. Otherwise go back to REFILL_REQ.
- Only one beat is outstanding at a time. mem_resp_valid outside REFILL_WAIT is ignored.
- The victim's valid bit is cleared at refill start, so a partial line never hits.
- IDLE and hit, stall=0: increment hit_count. Counters saturate at 32'hFFFF_FFFF.
- flush while idle: go to FLUSH. Clear valid for one set per cycle, set 0 to SETS-1, then IDLE. Round-robin pointers reset to 0.
- flush during refill: latch as pending. FLUSH starts on the cycle refill completes, instead of returning to IDLE.
- data_addr changing during refill has no effect on the refill. stop stays high until the current address hits.
- stall does not pause an in-flight refill or flush.

## Timing
- Reset values: state IDLE, all valid bits 0, pointers 0, pending flush 0, mem_req_valid 0, mem_req_addr 0, counters 0. stop=1 (empty cache). data is don't-care.
- reset mid-refill or mid-flush aborts in one cycle. Later responses are ignored.
- Hit latency: 0 cycles (combinational from data_addr).
- Zero-wait memory (ready=1, response the cycle after acceptance): 2 cycles per beat. stop falls 2*LINE_WORDS+1 cycles after the miss cycle (17 at defaults).
- Backpressure: mem_req_valid and mem_req_addr are held stable until mem_req_ready.
- Flush occupies exactly SETS cycles with stop=1.

## Structure
- Package ic_pkg holds: the state enum; width helpers for OFST_W, IDX_W and TAG_W as clog2-based functions; the WAYS legality check, an elaboration-time error.
- Sub-module ic_way: one way's tag, valid and data arrays. It provides a read port, a word write, a tag/valid write, and a per-set clear. The top instantiates WAYS copies through a generate loop.
- Replacement pointers, FSM and counters live in the top.

## Test plan
- Reset, fetch 0x0000_0040, memory returns word = address:
  - stop=1, requests 0x40…0x5C in order.
  - stop falls at cycle 17, data=0x40, miss_count=1.
  - Refetch 0x44 gives a hit, hit_count increments.
- Fetch 0x0000_0054 → request order 0x54, 0x58, 0x5C, 0x40, 0x44, 0x48, 0x4C, 0x50; data=0x54 on completion.
- Two-way replacement, all three addresses in the same set:
  - Fill 0x0000_0040 then 0x0000_8040; both then hit.
  - 0x0001_0040 misses and evicts way 0, so 0x40 misses again while 0x8040 still hits.
- Hold mem_req_ready low for 5 cycles on beat 3 → valid and address stable, no beat lost or duplicated, line correct.
- Pulse flush on beat 4 of a refill → refill completes, then 1024 cycles of FLUSH with stop=1; afterwards 0x40 misses.
- Assert reset during beat 5 → all outputs at reset values next cycle, stray mem_resp_valid ignored, next fetch misses.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Field widths derive from the cache geometry so every file slices addresses identically.
package ic_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        FLUSH       = 2'd3
    } state_t;

    function automatic int ofst_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int line_words);
        return addr_w - idx_width(sets) - ofst_width(line_words) - 2;
    endfunction

    // A single-way cache still needs a one-bit pointer/victim field.
    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic bit ways_legal(input int ways);
        return (ways == 1) || (ways == 2) || (ways == 4);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ic_way.sv
// One cache way: tag and data arrays plus per-set valid bits.
// Combinational read port; separate word write, tag/valid write and per-set clear.
module ic_way
    import ic_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 1024,
    localparam int OFST_W    = ofst_width(LINE_WORDS),
    localparam int IDX_W     = idx_width(SETS),
    localparam int TAG_W     = tag_width(ADDR_W, SETS, LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFST_W-1:0] rd_ofst,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [OFST_W-1:0] word_ofst,
    input  logic [WORD_W-1:0] word_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_idx,
    input  logic [TAG_W-1:0]  tag_data,
    input  logic              tag_valid,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);

    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [WORD_W-1:0] data_mem [SETS*LINE_WORDS];
    logic [SETS-1:0]   valid_q;

    // NOTE: the tag and data arrays are never reset; a clear valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{word_idx, word_ofst}] <= word_data;
        end
        if (tag_we) begin
            tag_mem[tag_idx] <= tag_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (tag_we) begin
                valid_q[tag_idx] <= tag_valid;
            end
            if (clr_en) begin
                valid_q[clr_idx] <= 1'b0;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_ofst}];

endmodule

// File: rtl/ic_assoc.sv
// Set-associative instruction cache: combinational hit path, critical-word-first refill,
// round-robin replacement, whole-cache flush and saturating hit/miss counters.
module ic_assoc
    import ic_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 1024,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data,
    output logic              stop,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int OFST_W = ofst_width(LINE_WORDS);
    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(ADDR_W, SETS, LINE_WORDS);
    localparam int WAY_W  = way_width(WAYS);

    if (!ways_legal(WAYS)) begin : g_bad_ways
        $error("ic_assoc: WAYS must be 1, 2 or 4");
    end

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFST_W-1:0] req_ofst;
    logic              unused_addr_bits;

    assign req_ofst         = data_addr[OFST_W+1:2];
    assign req_idx          = data_addr[OFST_W+IDX_W+1:OFST_W+2];
    assign req_tag          = data_addr[ADDR_W-1:OFST_W+IDX_W+2];
    assign unused_addr_bits = ^data_addr[1:0];

    state_t            state;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFST_W-1:0] beat_ofst;
    logic [OFST_W-1:0] beat_cnt;
    logic [WAY_W-1:0]  victim_q;
    logic              flush_pend;
    logic [IDX_W-1:0]  flush_idx;
    logic [WAY_W-1:0]  rr_ptr [SETS];

    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_match;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [WORD_W-1:0] way_data [WAYS];

    logic              hit;
    logic              miss_start;
    logic              beat_done;
    logic              line_done;
    logic [OFST_W-1:0] beat_next;
    logic [WAY_W-1:0]  victim_next;

    assign hit        = |way_match;
    assign stop       = (state != IDLE) || !hit;
    assign miss_start = (state == IDLE) && !hit && !stall && !flush;
    assign beat_done  = (state == REFILL_WAIT) && mem_resp_valid;
    assign line_done  = beat_done && (beat_cnt == OFST_W'(LINE_WORDS - 1));
    assign beat_next  = beat_ofst + OFST_W'(1);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        victim_next = rr_ptr[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim_next = WAY_W'(w);
            end
        end
    end

    always_comb begin
        data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) begin
                data = way_data[w];
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_match[w] = way_valid[w] && (way_tag[w] == req_tag);

        // Victim valid drops at refill start and rises with the tag when the line completes.
        ic_way #(
            .ADDR_W     (ADDR_W),
            .LINE_WORDS (LINE_WORDS),
            .SETS       (SETS)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .rd_idx    (req_idx),
            .rd_ofst   (req_ofst),
            .rd_valid  (way_valid[w]),
            .rd_tag    (way_tag[w]),
            .rd_data   (way_data[w]),
            .word_we   (beat_done && (victim_q == WAY_W'(w))),
            .word_idx  (idx_q),
            .word_ofst (beat_ofst),
            .word_data (mem_resp_data),
            .tag_we    ((miss_start && (victim_next == WAY_W'(w))) ||
                        (line_done && (victim_q == WAY_W'(w)))),
            .tag_idx   (miss_start ? req_idx : idx_q),
            .tag_data  (tag_q),
            .tag_valid (line_done),
            .clr_en    (state == FLUSH),
            .clr_idx   (flush_idx)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (state == FLUSH) begin
            rr_ptr[flush_idx] <= '0;
        end else if (line_done) begin
            rr_ptr[idx_q] <= (rr_ptr[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx_q] + WAY_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tag_q         <= '0;
            idx_q         <= '0;
            beat_ofst     <= '0;
            beat_cnt      <= '0;
            victim_q      <= '0;
            flush_pend    <= 1'b0;
            flush_idx     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            if ((state == IDLE) && hit && !stall) begin
                hit_count <= sat_inc(hit_count);
            end

            case (state)
                IDLE: begin
                    if (flush) begin
                        flush_idx <= '0;
                        state     <= FLUSH;
                    end else if (miss_start) begin
                        tag_q         <= req_tag;
                        idx_q         <= req_idx;
                        beat_ofst     <= req_ofst;
                        beat_cnt      <= '0;
                        victim_q      <= victim_next;
                        miss_count    <= sat_inc(miss_count);
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {req_tag, req_idx, req_ofst, 2'b00};
                        state         <= REFILL_REQ;
                    end
                end

                REFILL_REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= REFILL_WAIT;
                    end
                end

                REFILL_WAIT: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        if (line_done) begin
                            if (flush_pend || flush) begin
                                flush_pend <= 1'b0;
                                flush_idx  <= '0;
                                state      <= FLUSH;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_ofst     <= beat_next;
                            beat_cnt      <= beat_cnt + OFST_W'(1);
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {tag_q, idx_q, beat_next, 2'b00};
                            state         <= REFILL_REQ;
                        end
                    end
                end

                FLUSH: begin
                    if (flush_idx == IDX_W'(SETS - 1)) begin
                        state <= IDLE;
                    end else begin
                        flush_idx <= flush_idx + IDX_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
